fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  PC register, synchronous instruction-memory front end and IF/ID pipeline register of the 5-stage core.
//  Sits directly upstream of the hazard detection unit and consumes its ldPC / ld_IF_ID outputs plus ID-stage branch redirects.
//  Hides the 1-cycle imem read latency with a one-entry hold buffer, so stalls never lose or duplicate a fetched word.
// PARAMETERS
//  PC_W    12  width of PC and imem address (word-addressed)
//  INST_W  19  instruction width; opcode = inst[INST_W-1 -: 6]
//  NOP     '0  instruction injected on flush/bubble
// PORTS
//  clk           in   1       single clock, rising edge
//  rst           in   1       synchronous, active-high reset
//  ldPC          in   1       PC update enable from hazard unit
//  ld_IF_ID      in   1       IF/ID load enable from hazard unit
//  IF_ID_flush   in   1       squash IF/ID contents this cycle (taken branch/jump)
//  redirect      in   1       ID stage requests PC <- redirect_pc
//  redirect_pc   in   PC_W    branch/jump target
//  imem_addr     out  PC_W    synchronous imem read address (data returns next cycle)
//  imem_rdata    in   INST_W  imem data for address presented previous cycle
//  IF_ID_inst    out  INST_W  instruction to decode
//  IF_ID_pc1     out  PC_W    PC+1 of that instruction
//  IF_ID_valid   out  1       1 = IF_ID_inst is a real fetched instruction
// BEHAVIOUR
//  Reset: pc=0, state=BOOT, hold buffer empty, IF_ID_inst=NOP, IF_ID_pc1=0, IF_ID_valid=0; imem_addr=0.
//  imem_addr = pc combinationally; word for pc appears on imem_rdata one cycle later (tag = pc of that cycle).
//  next pc: redirect&ldPC -> redirect_pc; else ldPC -> pc+1 (wraps 2^PC_W-1 -> 0); else hold.
//  FSM (fetch-word qualification):
//   BOOT   : first cycle after rst; imem_rdata invalid. -> RUN.
//   RUN    : imem_rdata valid for tag. On redirect&ldPC -> SQUASH.
//   SQUASH : imem_rdata belongs to the abandoned path; discard it. -> RUN (or stay SQUASH on a back-to-back redirect).
//  Source word = hold buffer if full, else imem_rdata when state==RUN and word valid.
//  ld_IF_ID=1: IF/ID <- source word, pc1=tag+1, valid=1; hold buffer drains. No source word -> IF/ID <- NOP, valid=0.
//  ld_IF_ID=0: IF/ID holds; a valid word arriving from imem is captured in the hold buffer (never overwritten while full).
//  ldPC=0 while hold buffer full is guaranteed by hazard unit; if violated, the newer word is dropped (assertion in sim).
//  IF_ID_flush has priority over ld_IF_ID: IF/ID <- NOP, valid=0; hold buffer cleared.
//  redirect without ldPC is ignored. redirect and flush in same cycle: both apply, FSM -> SQUASH.
//  rst mid-stall/mid-redirect: all state returns to reset values next edge; no word leaks.
//  Latency: PC change -> IF_ID_valid for that PC = 2 cycles with no stalls.
// CONFIGURATION
//  FETCH_STALL_CNT_EN defined: adds output stall_cnt [15:0], counts cycles with ld_IF_ID=0 or IF_ID_flush=1,
//   saturates at 16'hFFFF, cleared by rst. Undefined: port and counter absent, no other change.
// STRUCTURE
//  Package cpu_pkg: PC_W, INST_W, NOP constant, opcode field slice, fetch_state_t enum {BOOT,RUN,SQUASH}.
//  One sub-module: fetch_hold_buf (one-entry buffer: word+tag, full flag, push/pop/clear).
//  PC register, FSM and IF/ID register stay in fetch_stage.
// TESTING
//  Straight-line: rst 2 cycles, ldPC=ld_IF_ID=1, imem[i]=i+100 -> IF_ID_inst 100,101,102... from cycle 2, pc1=1,2,3.
//  Load-use stall: ldPC=0, ld_IF_ID=0 for 1 cycle at pc=5 -> IF/ID holds inst 104, inst 105 issued next, none lost or duplicated.
//  Taken branch at pc=7 to 0x20 with flush -> one NOP bubble (valid=0), SQUASH discards word@8, next valid inst = imem[0x20], pc1=0x21.
//  Back-to-back redirects 0x20 then 0x40 -> no word from 0x20 path reaches IF/ID with valid=1.
//  Wrap: pc=0xFFF, ldPC=1 -> pc=0x000, IF_ID_pc1=0x000 for inst@0xFFF.
//  rst asserted during stall with hold buffer full -> next cycle IF_ID_valid=0, pc=0, state BOOT; with FETCH_STALL_CNT_EN stall_cnt=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the fetch front end: PC/instruction widths, NOP encoding, fetch FSM states.
// Latency: n/a (types only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int PC_W   = 12;
    localparam int INST_W = 19;
    localparam int OPC_W  = 6;

    typedef logic [PC_W-1:0]   pc_t;
    typedef logic [INST_W-1:0] inst_t;

    localparam inst_t NOP = '0;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        SQUASH
    } fetch_state_t;

    // A fetched word together with the address it was read from.
    typedef struct packed {
        pc_t   tag;
        inst_t inst;
    } fetch_word_t;

    function automatic logic [OPC_W-1:0] opcode(input inst_t inst);
        return inst[INST_W-1 -: OPC_W];
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch stage bus: hazard-unit controls, ID redirect, imem port and IF/ID register outputs.
// Latency: n/a (wiring only).
// Backpressure: ldPC / ld_IF_ID from the hazard unit stall the stage.
interface fetch_stage_if;
    import cpu_pkg::*;

    logic  ldPC;
    logic  ld_IF_ID;
    logic  IF_ID_flush;
    logic  redirect;
    pc_t   redirect_pc;
    pc_t   imem_addr;
    inst_t imem_rdata;
    inst_t IF_ID_inst;
    pc_t   IF_ID_pc1;
    logic  IF_ID_valid;

    modport master (
        input  ldPC, ld_IF_ID, IF_ID_flush, redirect, redirect_pc, imem_rdata,
        output imem_addr, IF_ID_inst, IF_ID_pc1, IF_ID_valid
    );

    modport slave (
        output ldPC, ld_IF_ID, IF_ID_flush, redirect, redirect_pc, imem_rdata,
        input  imem_addr, IF_ID_inst, IF_ID_pc1, IF_ID_valid
    );

endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry holding register for a fetched word (word + tag) while IF/ID is stalled.
// Latency: push visible as full/dat the cycle after the push edge.
// Backpressure: a push while full is ignored; clear has priority over pop and push.
module fetch_hold_buf
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic        pop,
    input  logic        clear,
    input  fetch_word_t push_dat,
    output logic        full,
    output fetch_word_t dat
);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            full <= 1'b0;
        end else if (pop) begin
            full <= 1'b0;
        end else if (push) begin
            full <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dat <= '0;
        end else if (push && !full) begin
            dat <= push_dat;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// PC register, synchronous imem front end and IF/ID register; FETCH_STALL_CNT_EN adds stall_cnt.
// Latency: PC change -> IF_ID_valid for that PC in 2 cycles without stalls.
// Backpressure: ld_IF_ID=0 holds IF/ID and parks the in-flight imem word in a one-entry buffer.
module fetch_stage
    import cpu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    fetch_stage_if.master fif
`ifdef FETCH_STALL_CNT_EN
    ,
    output logic [15:0]   stall_cnt
`endif
);

    fetch_state_t state_q, state_d;
    pc_t          pc_q, pc_d, tag_q;
    logic         adv_q, dup_q, dup_d;
    logic         take_redirect, cur_vld, src_vld, cur_taken;
    logic         load, hold_push, hold_pop, hold_full;
    fetch_word_t  hold_dat, imem_dat, src_dat;

    assign take_redirect = fif.redirect & fif.ldPC;
    assign fif.imem_addr = pc_q;

    always_comb begin
        pc_d = pc_q;
        if (take_redirect) begin
            pc_d = fif.redirect_pc;
        end else if (fif.ldPC) begin
            pc_d = pc_q + pc_t'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            BOOT:    state_d = take_redirect ? SQUASH : RUN;
            RUN:     if (take_redirect) state_d = SQUASH;
            SQUASH:  state_d = take_redirect ? SQUASH : RUN;
            default: state_d = BOOT;
        endcase
    end

    // A held PC re-reads the same word next cycle; dup_q marks that repeat as already consumed.
    assign imem_dat  = '{tag: tag_q, inst: fif.imem_rdata};
    assign cur_vld   = (state_q == RUN) && !dup_q;
    assign src_vld   = hold_full | cur_vld;
    assign src_dat   = hold_full ? hold_dat : imem_dat;
    assign load      = fif.ld_IF_ID & ~fif.IF_ID_flush;
    assign hold_pop  = load & hold_full;
    assign hold_push = ~fif.ld_IF_ID & ~fif.IF_ID_flush & cur_vld & ~hold_full;
    assign cur_taken = cur_vld & (fif.IF_ID_flush | hold_push | (load & ~hold_full));
    assign dup_d     = (state_q == RUN) & ~adv_q & (~cur_vld | cur_taken);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= '0;
            tag_q   <= '0;
            adv_q   <= 1'b0;
            dup_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tag_q   <= pc_q;
            adv_q   <= fif.ldPC;
            dup_q   <= dup_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fif.IF_ID_inst  <= NOP;
            fif.IF_ID_pc1   <= '0;
            fif.IF_ID_valid <= 1'b0;
        end else if (fif.IF_ID_flush) begin
            fif.IF_ID_inst  <= NOP;
            fif.IF_ID_valid <= 1'b0;
        end else if (fif.ld_IF_ID) begin
            if (src_vld) begin
                fif.IF_ID_inst  <= src_dat.inst;
                fif.IF_ID_pc1   <= src_dat.tag + pc_t'(1);
                fif.IF_ID_valid <= 1'b1;
            end else begin
                fif.IF_ID_inst  <= NOP;
                fif.IF_ID_valid <= 1'b0;
            end
        end
    end

    fetch_hold_buf u_hold (
        .clk      (clk),
        .rst      (rst),
        .push     (hold_push),
        .pop      (hold_pop),
        .clear    (fif.IF_ID_flush),
        .push_dat (imem_dat),
        .full     (hold_full),
        .dat      (hold_dat)
    );

    // Advancing the PC while a word is parked would drop the next fetched word.
    drop_guard: assert property (@(posedge clk) disable iff (rst)
        !(hold_full && fif.ldPC && !fif.ld_IF_ID && !fif.IF_ID_flush));

`ifdef FETCH_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if ((!fif.ld_IF_ID || fif.IF_ID_flush) && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule
